// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - eight-digit seven-segment scan controller with frame-synchronous loading
// Option macro: SSD_SCAN_CTRL_LEADING_ZERO_BLANK_EN (leading-zero suppression).
module ssd_scan_ctrl #(
   parameter int DIV          = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        ssd_scan_ctrl_port_clk,
   input  logic        ssd_scan_ctrl_port_rst_n,
   input  logic        ssd_scan_ctrl_port_load_valid,
   output logic        ssd_scan_ctrl_port_load_ready,
   input  logic [31:0] ssd_scan_ctrl_port_load_data,
   input  logic [7:0]  ssd_scan_ctrl_port_load_dp,
   input  logic [7:0]  ssd_scan_ctrl_port_load_en,
   output logic [7:0]  ssd_scan_ctrl_port_an,
   output logic [6:0]  ssd_scan_ctrl_port_cc,
   output logic        ssd_scan_ctrl_port_dp,
   output logic        ssd_scan_ctrl_port_frame_tick
);
   localparam int            CW         = $clog2(DIV);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [0:0]    ST_BLANK   = 1'b0;
   localparam logic [0:0]    ST_DRIVE   = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   act_data_q, act_data_d, pnd_data_q, pnd_data_d;
   logic [7:0]    act_dp_q, act_dp_d, act_en_q, act_en_d;
   logic [7:0]    pnd_dp_q, pnd_dp_d, pnd_en_q, pnd_en_d;
   logic          pend_q, pend_d;
   logic [7:0]    an_q, an_d;
   logic [6:0]    cc_q, cc_d;
   logic          dp_q, dp_d;
   logic          tick_q, tick_d;
   logic          boundary, xfer;
   logic [7:0]    vis_mask;
   logic [3:0]    nib;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0:    glyph = 7'b1000000;
         4'h1:    glyph = 7'b1111001;
         4'h2:    glyph = 7'b0100100;
         4'h3:    glyph = 7'b0110000;
         4'h4:    glyph = 7'b0011001;
         4'h5:    glyph = 7'b0010010;
         4'h6:    glyph = 7'b0000010;
         4'h7:    glyph = 7'b1111000;
         4'h8:    glyph = 7'b0000000;
         4'h9:    glyph = 7'b0010000;
         4'hA:    glyph = 7'b0001000;
         4'hB:    glyph = 7'b0000011;
         4'hC:    glyph = 7'b1000110;
         4'hD:    glyph = 7'b0100001;
         4'hE:    glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

   // The slot counter runs across the whole slot; BLANK occupies its first BLANK_CYCLES counts.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      idx_d    = idx_q;
      boundary = 1'b0;
      if (state_q == ST_BLANK) begin
         if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
      end else if (cnt_q == SLOT_LAST) begin
         state_d  = ST_BLANK;
         cnt_d    = '0;
         idx_d    = idx_q + 3'd1;
         boundary = (idx_q == 3'd7);
      end
   end

   always_comb begin
      xfer       = ssd_scan_ctrl_port_load_valid & ~pend_q;
      act_data_d = act_data_q;
      act_dp_d   = act_dp_q;
      act_en_d   = act_en_q;
      pnd_data_d = pnd_data_q;
      pnd_dp_d   = pnd_dp_q;
      pnd_en_d   = pnd_en_q;
      pend_d     = pend_q;
      if (boundary && pend_q) begin
         act_data_d = pnd_data_q;
         act_dp_d   = pnd_dp_q;
         act_en_d   = pnd_en_q;
         pend_d     = 1'b0;
      end
      // xfer and a boundary apply are mutually exclusive, since xfer needs pend_q low.
      if (xfer) begin
         pnd_data_d = ssd_scan_ctrl_port_load_data;
         pnd_dp_d   = ssd_scan_ctrl_port_load_dp;
         pnd_en_d   = ssd_scan_ctrl_port_load_en;
         pend_d     = 1'b1;
      end
   end

`ifdef SSD_SCAN_CTRL_LEADING_ZERO_BLANK_EN
   always_comb begin
      vis_mask = act_en_d;
      for (int k = 1; k < 8; k++) begin
         if (((act_data_d >> (4 * k)) == 32'd0) && !act_dp_d[k]) vis_mask[k] = 1'b0;
      end
   end
`else
   assign vis_mask = act_en_d;
`endif

   assign nib = act_data_d[4*idx_d +: 4];

   // Outputs are decoded from next-state values so the registered pins line up with the state.
   always_comb begin
      an_d   = 8'hFF;
      cc_d   = 7'h7F;
      dp_d   = 1'b1;
      tick_d = boundary;
      if (state_d == ST_DRIVE) begin
         an_d[idx_d] = ~vis_mask[idx_d];
         cc_d        = glyph(nib);
         dp_d        = ~act_dp_d[idx_d];
      end
   end

   always_ff @(posedge ssd_scan_ctrl_port_clk or negedge ssd_scan_ctrl_port_rst_n) begin
      if (!ssd_scan_ctrl_port_rst_n) begin
         state_q    <= ST_BLANK;
         cnt_q      <= '0;
         idx_q      <= 3'd0;
         act_data_q <= 32'd0;
         act_dp_q   <= 8'h00;
         act_en_q   <= 8'h00;
         pnd_data_q <= 32'd0;
         pnd_dp_q   <= 8'h00;
         pnd_en_q   <= 8'h00;
         pend_q     <= 1'b0;
         an_q       <= 8'hFF;
         cc_q       <= 7'h7F;
         dp_q       <= 1'b1;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         act_data_q <= act_data_d;
         act_dp_q   <= act_dp_d;
         act_en_q   <= act_en_d;
         pnd_data_q <= pnd_data_d;
         pnd_dp_q   <= pnd_dp_d;
         pnd_en_q   <= pnd_en_d;
         pend_q     <= pend_d;
         an_q       <= an_d;
         cc_q       <= cc_d;
         dp_q       <= dp_d;
         tick_q     <= tick_d;
      end
   end

   assign ssd_scan_ctrl_port_load_ready = ~pend_q;
   assign ssd_scan_ctrl_port_an         = an_q;
   assign ssd_scan_ctrl_port_cc         = cc_q;
   assign ssd_scan_ctrl_port_dp         = dp_q;
   assign ssd_scan_ctrl_port_frame_tick = tick_q;

endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

- Time-multiplexed scan controller for the eight-digit common-anode seven-segment display on the Nexys A7-100T.
- Holds a 32-bit hex word (eight nibbles), per-digit decimal points and a per-digit enable mask.
- Drives one digit at a time, with an anode-off blanking gap between digits to suppress ghosting.
- New values are accepted through a valid/ready handshake and applied only at a frame boundary, so the display never shows a torn word.

## Interface
- DIV, 100000: clock cycles per digit slot (1 ms at 100 MHz); must be > BLANK_CYCLES.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; must be ≥ 1.
- ssd_scan_ctrl_port_clk  in  1  system clock, rising edge.
- ssd_scan_ctrl_port_rst_n  in  1  asynchronous active-low reset.
- ssd_scan_ctrl_port_load_valid  in  1  load request.
- ssd_scan_ctrl_port_load_ready  out  1  high when no load is pending.
- ssd_scan_ctrl_port_load_data  in  32  nibble k drives digit k (digit 0 is rightmost).
- ssd_scan_ctrl_port_load_dp  in  8  bit k=1 lights the decimal point of digit k.
- ssd_scan_ctrl_port_load_en  in  8  bit k=1 enables digit k.
- ssd_scan_ctrl_port_an  out  8  anodes, active-low.
- ssd_scan_ctrl_port_cc  out  7  segments {g,f,e,d,c,b,a}, active-low.
- ssd_scan_ctrl_port_dp  out  1  decimal point, active-low.
- ssd_scan_ctrl_port_frame_tick  out  1  one-cycle pulse on each digit-7→0 wrap.

## Operation
- **Registers**
  - Active set: data, dp, en. Reset values 0, 0, 8'h00, so the display is dark.
  - Pending set: same three fields plus a pending flag.
  - Slot counter: $clog2(DIV) bits. Digit index: 3 bits.
- **FSM states: BLANK, DRIVE.**
  - BLANK: an=8'hFF, cc=7'h7F, dp=1.
    - Lasts BLANK_CYCLES cycles, then goes to DRIVE with the same index.
  - DRIVE: an[idx]=0 only if en[idx]=1, otherwise all anodes stay high.
    - cc = hex decode of nibble idx, using glyphs 0–9 and A–F (standard Nexys active-low patterns).
    - dp = ~dp[idx].
    - Lasts DIV−BLANK_CYCLES cycles, then goes to BLANK with idx+1 mod 8.
- **Frame boundary**
  - Defined as the edge where DRIVE at idx=7 transitions to BLANK at idx=0.
  - On that edge, frame_tick is registered high for exactly one cycle.
  - If the pending flag is set, the pending set is copied into the active set and the flag is cleared.
- **Handshake**
  - load_ready = ~pending.
  - A transfer occurs on an edge where valid && ready: the inputs are captured into the pending set and the pending flag is set.
  - Inputs are ignored while ready=0. valid may drop without a transfer.
  - A transfer on the frame-boundary edge itself loads only the pending set; it is applied at the next boundary.
- **Reset**
  - Asynchronous and immediate, including mid-slot.
  - Resets to state BLANK, idx=0, counter=0, pending=0.
  - Outputs on reset: an=8'hFF, cc=7'h7F, dp=1, load_ready=1, frame_tick=0.
- Undefined nibble values are impossible; every 4-bit code has a glyph. No z is ever driven.

## Timing
- All outputs are registered and change only on a clock edge (reset excepted).
- After reset release:
  - First DRIVE of digit 0 begins at cycle BLANK_CYCLES.
  - First frame_tick occurs at cycle 8·DIV.
- Display refresh rate is clk/(8·DIV): 125 Hz per digit at default settings.
- load_ready falls on the edge after the transfer.
- load_ready rises on the edge after the applying frame boundary.
- Worst-case load-to-display latency: 8·DIV + BLANK_CYCLES cycles.

## Configuration
- Macro: SSD_SCAN_CTRL_LEADING_ZERO_BLANK_EN.
- **Defined:** leading-zero suppression.
  - A digit k>0 is forced dark (anode high) in DRIVE when every nibble k..7 is 0 and dp[k]=0.
  - Digit 0 is never suppressed.
  - The suppression mask is computed from the active set only.
- **Undefined:** all enabled digits are shown, including leading zeros.

## Test plan
- **Reset dark:** DIV=8, BLANK_CYCLES=2; assert rst_n=0 mid-DRIVE.
  - an=8'hFF, cc=7'h7F, dp=1, load_ready=1 immediately, with no clock edge required.
- **Single load:** load data=32'h0000_00A5, en=8'h03, dp=8'h01.
  - After the next frame_tick: digit 0 shows cc=7'b0010010 with dp=0; digit 1 shows cc=7'b0001000.
  - Anodes 2–7 never go low.
- **Scan order:** after the load, sample each DRIVE.
  - an walks FE, FD, FB, F7, EF, DF, BF, 7F; each digit is driven for 6 cycles with 2 all-high cycles between digits.
  - frame_tick occurs every 64 cycles.
- **Back-pressure:** hold valid through two consecutive words 32'h1111_1111 then 32'h2222_2222.
  - ready is low from the first transfer until the next boundary.
  - The second word transfers only after ready returns to 1, and displays one frame later.
  - No torn frame is ever shown.
- **Boundary collision:** a transfer on the exact frame_tick edge.
  - The word is not applied at that boundary; it appears after the following frame_tick.
- **Leading-zero blanking (macro defined):** data=32'h0000_0120, en=8'hFF, dp=0.
  - Digits 3–7 stay dark; digits 0–2 show 0, 2, 1.
  - With dp[5]=1, digit 5 shows 0 with its decimal point.
